// File: rtl/seg7led_sequencer_if.sv
// Update-request handshake and driver control-port bundle for seg7led_sequencer.
// Master = update source side, slave = sequencer side.
interface seg7led_sequencer_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned DATA_W = DIGITS * 4;

  logic                req_valid;
  logic                req_ready;
  logic [DATA_W-1:0]   req_data;
  logic [DIGITS-1:0]   req_on;
  logic [DIGITS-1:0]   req_dp;
  logic [DIGITS-1:0]   req_blink;
  logic [1:0]          ctrl_address;
  logic                ctrl_write;
  logic [31:0]         ctrl_writedata;

  modport master (
    output req_valid, req_data, req_on, req_dp, req_blink,
    input  req_ready, ctrl_address, ctrl_write, ctrl_writedata
  );

  modport slave (
    input  req_valid, req_data, req_on, req_dp, req_blink,
    output req_ready, ctrl_address, ctrl_write, ctrl_writedata
  );
endinterface

// File: rtl/seg7led_sequencer.sv
// Shadows a whole-display update and replays it as data/on/dp register writes to the 7-seg driver.
// Optional blink refresh of the digit-enable register is built when SEG7LED_SEQUENCER_BLINK_EN is defined.
module seg7led_sequencer #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seg7led_sequencer_if.slave   bus,
  output logic                 busy
);
  localparam int unsigned DATA_W = DIGITS * 4;
  localparam int unsigned CNT_W  = $clog2(BLINK_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_ON,
    S_WR_DP
`ifdef SEG7LED_SEQUENCER_BLINK_EN
    , S_BLINK_ON
`endif
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   sh_data;
  logic [DIGITS-1:0]   sh_on;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   eff_on;
  logic                handshake;
  logic                wr_q;
  logic [1:0]          addr_q;
  logic [31:0]         wdata_q;

  assign handshake          = (state == S_IDLE) && bus.req_valid;
  assign bus.req_ready      = (state == S_IDLE);
  assign busy               = (state != S_IDLE);
  assign bus.ctrl_write     = wr_q;
  assign bus.ctrl_address   = addr_q;
  assign bus.ctrl_writedata = wdata_q;

`ifdef SEG7LED_SEQUENCER_BLINK_EN
  logic [CNT_W-1:0]  blink_cnt;
  logic              phase;
  logic              blink_pend;
  logic [DIGITS-1:0] sh_blink;
  logic              wrap;

  assign wrap   = (blink_cnt == CNT_W'(BLINK_CYCLES - 1));
  assign eff_on = sh_on & ~(sh_blink & {DIGITS{phase}});

  // Half-period timer; a new request's clear of the pending refresh beats a coincident wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt  <= '0;
      phase      <= 1'b0;
      blink_pend <= 1'b0;
      sh_blink   <= '0;
    end else begin
      blink_cnt <= wrap ? '0 : blink_cnt + CNT_W'(1);
      if (wrap) phase <= ~phase;
      if (handshake) sh_blink <= bus.req_blink;
      if (handshake)
        blink_pend <= 1'b0;
      else if (wrap && (|sh_blink))
        blink_pend <= 1'b1;
      else if (state == S_IDLE)
        blink_pend <= 1'b0;
    end
  end
`else
  logic unused_blink;

  assign unused_blink = ^bus.req_blink;
  assign eff_on       = sh_on;
`endif

  // Sequencer; the control outputs are registered for the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      sh_data <= '0;
      sh_on   <= '1;
      sh_dp   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= 32'd0;
    end else begin
      wr_q    <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= 32'd0;
      case (state)
        S_IDLE: begin
          if (handshake) begin
            sh_data <= bus.req_data;
            sh_on   <= bus.req_on;
            sh_dp   <= bus.req_dp;
            state   <= S_WR_DATA;
            wr_q    <= 1'b1;
            addr_q  <= 2'd0;
            wdata_q <= 32'(bus.req_data);
          end
`ifdef SEG7LED_SEQUENCER_BLINK_EN
          else if (blink_pend) begin
            state   <= S_BLINK_ON;
            wr_q    <= 1'b1;
            addr_q  <= 2'd1;
            wdata_q <= 32'(eff_on);
          end
`endif
        end
        S_WR_DATA: begin
          state   <= S_WR_ON;
          wr_q    <= 1'b1;
          addr_q  <= 2'd1;
          wdata_q <= 32'(eff_on);
        end
        S_WR_ON: begin
          state   <= S_WR_DP;
          wr_q    <= 1'b1;
          addr_q  <= 2'd2;
          wdata_q <= 32'(sh_dp);
        end
        S_WR_DP: state <= S_IDLE;
`ifdef SEG7LED_SEQUENCER_BLINK_EN
        S_BLINK_ON: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg7led_sequencer.sv
// Directed bench for seg7led_sequencer (DIGITS=4, BLINK_CYCLES=8); blink cases follow SEG7LED_SEQUENCER_BLINK_EN.
module tb_seg7led_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];

  seg7led_sequencer_if #(.DIGITS(4)) bus ();

  seg7led_sequencer #(.DIGITS(4), .BLINK_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock; samples 1 time unit after the edge and logs any driver write.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ctrl_write === 1'b1) wq.push_back('{cyc, bus.ctrl_address, bus.ctrl_writedata});
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] on, input logic [3:0] dp,
                      input logic [3:0] bl, output int hs);
    logic r;
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    bus.req_on    = on;
    bus.req_dp    = dp;
    bus.req_blink = bl;
    hs = -1;
    for (int i = 0; i < 50 && hs < 0; i++) begin
      r = bus.req_ready;
      tick();
      if (r === 1'b1) hs = cyc;
    end
    bus.req_valid = 1'b0;
    bus.req_data  = 16'hDEAD;
    bus.req_on    = 4'h0;
    bus.req_dp    = 4'h0;
    bus.req_blink = 4'h0;
    if (hs < 0) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_wr(input string tag, input int idx, input int ecyc,
                          input logic [1:0] ea, input logic [31:0] ed);
    if (idx < wq.size()) begin
      check({tag, "_cyc"}, 32'(wq[idx].cyc), 32'(ecyc));
      check({tag, "_addr"}, 32'(wq[idx].a), 32'(ea));
      check({tag, "_data"}, wq[idx].d, ed);
    end else begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, hs2, rel;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_on    = '0;
    bus.req_dp    = '0;
    bus.req_blink = '0;

    // Reset state and quiet idle
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_ready", 32'(bus.req_ready), 32'd1);
      check("idle_write", 32'(bus.ctrl_write), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Single update: three consecutive writes
    wq.delete();
    send(16'h12AF, 4'hF, 4'h2, 4'h0, hs);
    tick(); tick();
    check("seq_ready_low", 32'(bus.req_ready), 32'd0);
    check("seq_busy_high", 32'(busy), 32'd1);
    tick();
    check("seq_ready_back", 32'(bus.req_ready), 32'd1);
    check("seq_busy_low", 32'(busy), 32'd0);
    tick();
    check("seq_nwrites", 32'(wq.size()), 32'd3);
    check_wr("seq0", 0, hs,     2'd0, 32'h12AF);
    check_wr("seq1", 1, hs + 1, 2'd1, 32'hF);
    check_wr("seq2", 2, hs + 2, 2'd2, 32'h2);

    // Back-to-back updates with valid held high
    wq.delete();
    send(16'h3456, 4'hA, 4'h1, 4'h0, hs);
    send(16'h9ABC, 4'h5, 4'h8, 4'h0, hs2);
    repeat (4) tick();
    check("b2b_spacing", 32'(hs2 - hs), 32'd4);
    check("b2b_nwrites", 32'(wq.size()), 32'd6);
    check_wr("b2b0", 0, hs,      2'd0, 32'h3456);
    check_wr("b2b1", 1, hs + 1,  2'd1, 32'hA);
    check_wr("b2b2", 2, hs + 2,  2'd2, 32'h1);
    check_wr("b2b3", 3, hs2,     2'd0, 32'h9ABC);
    check_wr("b2b4", 4, hs2 + 1, 2'd1, 32'h5);
    check_wr("b2b5", 5, hs2 + 2, 2'd2, 32'h8);

`ifdef SEG7LED_SEQUENCER_BLINK_EN
    // Handshake at the 7th edge after reset so the first wrap lands while in WR_DATA
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rel = cyc;
    wq.delete();
    repeat (6) tick();
    send(16'h1234, 4'hF, 4'h0, 4'h1, hs);
    repeat (5) tick();
    check("wrap_hs_edge", 32'(hs), 32'(rel + 7));
    check("wrap_nwrites", 32'(wq.size()), 32'd4);
    check_wr("wrap0", 0, hs, 2'd0, 32'h1234);
    if (wq.size() > 2) begin
      check("wrap1_addr", 32'(wq[1].a), 32'd1);
      check("wrap2_addr", 32'(wq[2].a), 32'd2);
    end
    check_wr("wrap_blink", 3, hs + 4, 2'd1, 32'hE);

    // Periodic refresh: address-1 writes alternating F/E every 8 clocks
    wq.delete();
    repeat (36) tick();
    check("blink_nwrites", 32'(wq.size()), 32'd4);
    check_wr("blink0", 0, hs + 10, 2'd1, 32'hF);
    check_wr("blink1", 1, hs + 18, 2'd1, 32'hE);
    check_wr("blink2", 2, hs + 26, 2'd1, 32'hF);
    check_wr("blink3", 3, hs + 34, 2'd1, 32'hE);
`endif

    // Reset while the ON write is on the port
    wq.delete();
    send(16'h5555, 4'h7, 4'h3, 4'h0, hs);
    tick();
    check("rst_mid_addr", 32'(bus.ctrl_address), 32'd1);
    reset_n = 1'b0;
    tick();
    check("rst_mid_write", 32'(bus.ctrl_write), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_wdata", bus.ctrl_writedata, 32'd0);
    reset_n = 1'b1;
    tick();
    wq.delete();
    send(16'hBEEF, 4'h3, 4'h4, 4'h0, hs);
    repeat (3) tick();
    check("post_rst_nwrites", 32'(wq.size()), 32'd3);
    check_wr("post0", 0, hs,     2'd0, 32'hBEEF);
    check_wr("post1", 1, hs + 1, 2'd1, 32'h3);
    check_wr("post2", 2, hs + 2, 2'd2, 32'h4);

`ifndef SEG7LED_SEQUENCER_BLINK_EN
    // Without the blink build, blink selects never produce refresh writes
    wq.delete();
    send(16'h0F0F, 4'hF, 4'h0, 4'hF, hs);
    repeat (30) tick();
    check("noblink_nwrites", 32'(wq.size()), 32'd3);
    check_wr("noblink1", 1, hs + 1, 2'd1, 32'hF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
